change_voice: RTL and testbench

CHANGE_VOICE -- requirements
Module: change_voice

---
 rtl/change_voice.sv | 76 +++++++
 tb/tb_change_voice.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/change_voice.sv
// Octave-up voice changer: circular sample buffer written at the input rate
// and read either in step with the writer (pass-through) or at twice its rate.
module change_voice #(
  parameter int DEPTH = 768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RisingTone,
  input  logic        ready,
  input  logic [15:0] SampleIn,
  output logic [15:0] SampleOut,
  output logic [9:0]  SampleCount
);

  localparam int AW = 10;

  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wp_r;
  logic [AW-1:0] rp_r;
  logic [15:0]   out_r;
  logic [AW-1:0] wp_next_s;
  logic [AW-1:0] rp_step_s;
  logic          collide_s;

  // Pointer successors: writer advances by one, octave reader by two, both modulo DEPTH.
  always_comb begin
    wp_next_s = 10'd0;
    rp_step_s = 10'd0;
    collide_s = 1'b0;
    if (wp_r == AW'(DEPTH - 1)) begin
      wp_next_s = 10'd0;
    end else begin
      wp_next_s = wp_r + 10'd1;
    end
    if (rp_r >= AW'(DEPTH - 2)) begin
      rp_step_s = rp_r - AW'(DEPTH - 2);
    end else begin
      rp_step_s = rp_r + 10'd2;
    end
    collide_s = (rp_r == wp_r);
  end

  // Pointers and output sample; everything holds between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_r  <= 10'd0;
      rp_r  <= 10'd0;
      out_r <= 16'd0;
    end else if (ready) begin
      wp_r <= wp_next_s;
      if (RisingTone) begin
        rp_r <= rp_step_s;
        // A read landing on the slot being written returns the fresh sample.
        if (collide_s) begin
          out_r <= SampleIn;
        end else begin
          out_r <= mem_r[rp_r];
        end
      end else begin
        rp_r  <= wp_next_s;
        out_r <= SampleIn;
      end
    end
  end

  // Sample memory: written on strobes only; reset leaves the contents alone.
  always_ff @(posedge clk) begin
    if (!reset && ready) begin
      mem_r[wp_r] <= SampleIn;
    end
  end

  assign SampleOut   = out_r;
  assign SampleCount = wp_r;

endmodule

// File: tb/tb_change_voice.sv
// Self-checking bench for change_voice: hand-computed vector table, a buffer
// model feeding a scoreboard queue for long ramps, and reset/idle sequences.
module tb_change_voice;

  localparam int DEPTH = 768;

  typedef struct {
    logic [15:0] out;
    logic [9:0]  cnt;
  } exp_t;

  typedef struct {
    logic [15:0] din;
    logic        tone;
    logic [15:0] out;
    logic [9:0]  cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RisingTone = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] SampleIn = 16'd0;
  logic [15:0] SampleOut;
  logic [9:0]  SampleCount;

  exp_t sb_q[$];
  int   m_mem [DEPTH];
  int   m_wp = 0;
  int   m_rp = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [15:0] out_log [400];
  logic [9:0]  cnt_a;
  logic [9:0]  cnt_b;

  change_voice #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .RisingTone (RisingTone),
    .ready      (ready),
    .SampleIn   (SampleIn),
    .SampleOut  (SampleOut),
    .SampleCount(SampleCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One strobe; expected result from the table when given, else from the model.
  task automatic strobe(input logic [15:0] din, input logic tone, input bit use_tab,
                        input logic [15:0] t_out, input logic [9:0] t_cnt);
    exp_t        e;
    exp_t        g;
    logic [15:0] m_out;
    if (tone) begin
      m_out = (m_rp == m_wp) ? din : 16'(m_mem[m_rp]);
      m_rp  = (m_rp + 2) % DEPTH;
    end else begin
      m_out = din;
      m_rp  = (m_wp + 1) % DEPTH;
    end
    m_mem[m_wp] = int'(din);
    m_wp = (m_wp + 1) % DEPTH;
    if (use_tab) begin
      e.out = t_out;
      e.cnt = t_cnt;
    end else begin
      e.out = m_out;
      e.cnt = 10'(m_wp);
    end
    sb_q.push_back(e);
    @(negedge clk);
    SampleIn   = din;
    RisingTone = tone;
    ready      = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    g = sb_q.pop_front();
    check("strobe_out", {16'd0, SampleOut}, {16'd0, g.out});
    check("strobe_cnt", {22'd0, SampleCount}, {22'd0, g.cnt});
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    reset      = 1'b1;
    ready      = 1'b1;
    RisingTone = 1'b1;
    SampleIn   = 16'hDEAD;
    repeat (ncyc) @(posedge clk);
    #1;
    reset = 1'b0;
    ready = 1'b0;
    m_wp  = 0;
    m_rp  = 0;
  endtask

  initial begin
    vec_t tab[6];
    tab[0] = '{din: 16'h0A0A, tone: 1'b1, out: 16'h0A0A, cnt: 10'd402};
    tab[1] = '{din: 16'h0B0B, tone: 1'b1, out: 16'd1171, cnt: 10'd403};
    tab[2] = '{din: 16'h8000, tone: 1'b0, out: 16'h8000, cnt: 10'd404};
    tab[3] = '{din: 16'h7FFF, tone: 1'b1, out: 16'h7FFF, cnt: 10'd405};
    tab[4] = '{din: 16'hFFFF, tone: 1'b1, out: 16'd1174, cnt: 10'd406};
    tab[5] = '{din: 16'h5555, tone: 1'b0, out: 16'h5555, cnt: 10'd407};

    // Reset held two clocks with strobes present.
    do_reset(2);
    check("reset_out", {16'd0, SampleOut}, 32'd0);
    check("reset_cnt", {22'd0, SampleCount}, 32'd0);

    // Pass-through and hold over 511 idle clocks.
    strobe(16'h1234, 1'b0, 1'b1, 16'h1234, 10'd1);
    repeat (511) @(posedge clk);
    #1;
    check("hold_out", {16'd0, SampleOut}, 32'h1234);
    check("hold_cnt", {22'd0, SampleCount}, 32'd1);

    // Two laps of a ramp in pass-through, checking the wrap of the write index.
    do_reset(1);
    for (int k = 0; k < 1536; k++) begin
      strobe(16'(k), 1'b0, 1'b0, 16'd0, 10'd0);
      if (k == 766) cnt_a = SampleCount;
      if (k == 767) cnt_b = SampleCount;
    end
    check("wrap_767", {22'd0, cnt_a}, 32'd767);
    check("wrap_0", {22'd0, cnt_b}, 32'd0);

    // Octave-up from a fresh switch: bypass first, then every other old sample.
    for (int n = 0; n < 400; n++) begin
      strobe(16'(1536 + n), 1'b1, 1'b0, 16'd0, 10'd0);
      out_log[n] = SampleOut;
    end
    check("oct_n0", {16'd0, out_log[0]}, 32'd1536);
    check("oct_n1", {16'd0, out_log[1]}, 32'd770);
    check("oct_n2", {16'd0, out_log[2]}, 32'd772);
    check("oct_n383", {16'd0, out_log[383]}, 32'd1534);
    check("oct_n384", {16'd0, out_log[384]}, 32'd1536);
    check("oct_n385", {16'd0, out_log[385]}, 32'd1538);

    strobe(16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 10'd401);

    for (int i = 0; i < 6; i++) begin
      strobe(tab[i].din, tab[i].tone, 1'b1, tab[i].out, tab[i].cnt);
    end

    // Mode and data changes between strobes must not disturb anything.
    @(negedge clk);
    RisingTone = 1'b1;
    SampleIn   = 16'hCAFE;
    repeat (5) @(posedge clk);
    #1;
    RisingTone = 1'b0;
    check("idle_out", {16'd0, SampleOut}, 32'h5555);
    check("idle_cnt", {22'd0, SampleCount}, 32'd407);

    // Reset with strobes present must not write; read back old data incl. rp 767->1.
    do_reset(2);
    check("reset2_out", {16'd0, SampleOut}, 32'd0);
    check("reset2_cnt", {22'd0, SampleCount}, 32'd0);
    strobe(16'h0100, 1'b0, 1'b0, 16'd0, 10'd0);
    for (int n = 0; n < 400; n++) begin
      strobe(16'(16'h2000 + n), 1'b1, 1'b0, 16'd0, 10'd0);
      out_log[n] = SampleOut;
    end
    check("stale_407", {16'd0, out_log[203]}, 32'd1175);
    check("odd_wrap", {16'd0, out_log[384]}, 32'h2000);

    // Reset in the middle of octave-up operation.
    do_reset(1);
    strobe(16'h0001, 1'b0, 1'b0, 16'd0, 10'd0);
    for (int n = 0; n < 299; n++) begin
      strobe(16'(16'h3000 + n), 1'b1, 1'b0, 16'd0, 10'd0);
    end
    check("mid_cnt300", {22'd0, SampleCount}, 32'd300);
    do_reset(1);
    check("mid_rst_out", {16'd0, SampleOut}, 32'd0);
    check("mid_rst_cnt", {22'd0, SampleCount}, 32'd0);
    strobe(16'h4321, 1'b1, 1'b1, 16'h4321, 10'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
